egress_queue: RTL and testbench
===============================

EGRESS_QUEUE -- requirements
Module: egress_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue depth in 32-bit words (power of two, 2..64).
REQ-002 SHALL have parameter PORT_ID, default 2'b01, output port served (01, 10 or 11).
REQ-003 SHALL have ports clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have ports reset_n  input  1  synchronous active-low reset.
REQ-005 SHALL have ports fifo_out1, fifo_out2, fifo_out3  input  32 each  head words of the three ingress FIFOs.
REQ-006 SHALL have ports mux_sel  input  2  scheduler source select: 01/10/11 = fifo_out1/2/3, 00 = none.
REQ-007 SHALL have ports out_ram_wr  input  1  scheduler write strobe for this port.
REQ-008 SHALL have ports egress_valid  output  1  head word available.
REQ-009 SHALL have ports egress_ready  input  1  downstream accepts head word.
REQ-010 SHALL have ports egress_data  output  32  head word.
REQ-011 SHALL have ports count  output  $clog2(DEPTH)+1  words held.
REQ-012 SHALL have ports full, empty  output  1 each  occupancy flags.
REQ-013 SHALL have ports drop  output  1  one-cycle pulse when a write is discarded.

Function
REQ-014 Push SHALL occur when out_ram_wr=1 and mux_sel!=00; selected word stored unmodified at wr_ptr.
REQ-015 Pop SHALL occur when egress_valid=1 and egress_ready=1; rd_ptr advances.
REQ-016 egress_valid SHALL equal !empty; egress_data SHALL show mem[rd_ptr] combinationally (show-ahead, zero-latency head).
REQ-017 A pushed word SHALL appear on egress_data the cycle after the push edge if the queue was empty.
REQ-018 Pointers SHALL be $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 without gaps.
REQ-019 count SHALL update +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-020 full SHALL be count==DEPTH; empty SHALL be count==0; both registered-consistent with count.
REQ-021 Push while full with no pop SHALL be discarded, memory/pointers unchanged, drop=1 next cycle.
REQ-022 Push while full with simultaneous pop SHALL be accepted; count stays DEPTH.
REQ-023 out_ram_wr=1 with mux_sel=00 SHALL be discarded and raise drop.
REQ-024 egress_ready while empty SHALL have no effect.
REQ-025 drop SHALL be high for exactly one cycle per discarded write.

Reset
REQ-026 While reset_n=0 at a clock edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, drop=0, egress_valid=0.
REQ-027 Reset mid-operation SHALL discard all held words; memory contents need not clear; push/pop coincident with reset SHALL be ignored.

Configuration
REQ-028 Macro EGRESS_DROP_CNT_EN defined: SHALL add output drop_cnt (16 bits), incremented on each drop, saturating at 16'hFFFF, cleared by reset.
REQ-029 Macro undefined: drop_cnt port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-030 Shared package switch_pkg SHALL hold WORD_W=32, port-select typedef (SEL_NONE=00, SEL_P1=01, SEL_P2=10, SEL_P3=11).
REQ-031 Storage SHALL be sub-module egress_ram: one synchronous write port, one asynchronous read port, DEPTH x WORD_W.
REQ-032 Source mux, pointers, count, flags and drop logic SHALL reside in egress_queue.

Verification
REQ-033 Reset, then out_ram_wr=1, mux_sel=10, fifo_out2=32'hA5A5_0002, egress_ready=0 -> next cycle egress_valid=1, egress_data=32'hA5A5_0002, count=1.
REQ-034 Eight pushes of 1..8 (DEPTH=8) with egress_ready=0, then ninth push -> full=1, drop pulses once, draining yields 1..8 in order.
REQ-035 Full queue, push 9 with egress_ready=1 same cycle -> no drop, count=8, word 1 popped, word 9 last out.
REQ-036 Continuous push/pop over 20 words -> pointers wrap, count constant, output order matches input, no drops.
REQ-037 out_ram_wr=1, mux_sel=00 -> drop=1 one cycle, count unchanged; with EGRESS_DROP_CNT_EN, drop_cnt=1.
REQ-038 Queue holding 3 words, reset_n=0 one cycle concurrent with push -> count=0, empty=1, egress_valid=0 afterwards.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch definitions: datapath word width and the scheduler source-select encoding.
package switch_pkg;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      SEL_NONE = 2'b00,
      SEL_P1   = 2'b01,
      SEL_P2   = 2'b10,
      SEL_P3   = 2'b11
   } sel_e;
endpackage

// File: rtl/egress_queue_if.sv
// Scheduler write side and downstream egress handshake of one output port queue.
interface egress_queue_if;
   import switch_pkg::*;

   logic [WORD_W-1:0] fifo_out1, fifo_out2, fifo_out3;
   logic [1:0]        mux_sel;
   logic              out_ram_wr;
   logic              egress_valid;
   logic              egress_ready;
   logic [WORD_W-1:0] egress_data;

   modport master (output fifo_out1, fifo_out2, fifo_out3, mux_sel, out_ram_wr, egress_ready,
                   input  egress_valid, egress_data);
   modport slave  (input  fifo_out1, fifo_out2, fifo_out3, mux_sel, out_ram_wr, egress_ready,
                   output egress_valid, egress_data);
endinterface

// File: rtl/egress_ram.sv
// Queue storage: one synchronous write port, one asynchronous (show-ahead) read port.
module egress_ram
   import switch_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/egress_queue.sv
// Per-port egress queue: selects the scheduled ingress word, queues it, presents a show-ahead head.
// Optional saturating drop counter output when EGRESS_DROP_CNT_EN is defined.
module egress_queue
   import switch_pkg::*;
#(
   parameter int         DEPTH   = 8,
   parameter logic [1:0] PORT_ID = 2'b01
) (
   input  logic                     clk,
   input  logic                     reset_n,
   egress_queue_if.slave            q,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     drop
`ifdef EGRESS_DROP_CNT_EN
   ,
   output logic [15:0]              drop_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("egress_queue: DEPTH must be a power of two in 2..64");
   end
   if (PORT_ID == 2'b00) begin : g_bad_port
      $error("egress_queue: PORT_ID must be 01, 10 or 11");
   end

   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count_nxt;
   logic [WORD_W-1:0] src_word;
   logic              src_ok, push, pop, discard;

   always_comb begin
      src_word = '0;
      src_ok   = 1'b1;
      case (sel_e'(q.mux_sel))
         SEL_P1:  src_word = q.fifo_out1;
         SEL_P2:  src_word = q.fifo_out2;
         SEL_P3:  src_word = q.fifo_out3;
         default: src_ok   = 1'b0;
      endcase
   end

   // A pop frees the slot in the same cycle, so a push into a full queue survives if paired with one.
   assign pop     = !empty && q.egress_ready;
   assign push    = q.out_ram_wr && src_ok && (!full || pop);
   assign discard = q.out_ram_wr && !push;

   always_comb begin
      count_nxt = count;
      if (push && !pop)      count_nxt = count + 1'b1;
      else if (pop && !push) count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         drop   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == DEPTH_C);
         empty <= (count_nxt == '0);
         drop  <= discard;
      end
   end

`ifdef EGRESS_DROP_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset_n)                           drop_cnt <= '0;
      else if (discard && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
   end
`endif

   egress_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (push && reset_n),
      .waddr (wr_ptr),
      .wdata (src_word),
      .raddr (rd_ptr),
      .rdata (q.egress_data)
   );

   assign q.egress_valid = !empty;
endmodule

// File: tb/tb_egress_queue.sv
// Directed bench for egress_queue: queue-based reference model checked every cycle plus literal checks.
module tb_egress_queue;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] count;
   logic       full, empty, drop;
`ifdef EGRESS_DROP_CNT_EN
   logic [15:0] drop_cnt;
   int          m_dcnt;
`endif

   egress_queue_if bus();

   egress_queue #(.DEPTH(DEPTH), .PORT_ID(2'b01)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .q        (bus),
      .count    (count),
      .full     (full),
      .empty    (empty),
      .drop     (drop)
`ifdef EGRESS_DROP_CNT_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a plain FIFO of words; pop uses the occupancy before the edge.
   int mq[$];
   bit m_drop;

   always @(posedge clk) begin : model
      bit pop_m, push_m;
      int w;
      if (!reset_n) begin
         mq.delete();
         m_drop <= 1'b0;
`ifdef EGRESS_DROP_CNT_EN
         m_dcnt <= 0;
`endif
      end else begin
         pop_m  = (mq.size() != 0) && bus.egress_ready;
         push_m = bus.out_ram_wr && (bus.mux_sel != 2'b00) && (mq.size() < DEPTH || pop_m);
         case (bus.mux_sel)
            2'b01:   w = int'(bus.fifo_out1);
            2'b10:   w = int'(bus.fifo_out2);
            2'b11:   w = int'(bus.fifo_out3);
            default: w = 0;
         endcase
         if (pop_m)  void'(mq.pop_front());
         if (push_m) mq.push_back(w);
         m_drop <= bus.out_ram_wr && !push_m;
`ifdef EGRESS_DROP_CNT_EN
         if (bus.out_ram_wr && !push_m && m_dcnt < 65535) m_dcnt <= m_dcnt + 1;
`endif
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_valid", {31'b0, bus.egress_valid}, {31'b0, mq.size() != 0});
         if (mq.size() != 0) check("m_data", bus.egress_data, mq[0]);
         check("m_count", {28'b0, count}, mq.size());
         check("m_full",  {31'b0, full},  {31'b0, mq.size() == DEPTH});
         check("m_empty", {31'b0, empty}, {31'b0, mq.size() == 0});
         check("m_drop",  {31'b0, drop},  {31'b0, m_drop});
`ifdef EGRESS_DROP_CNT_EN
         check("m_drop_cnt", {16'b0, drop_cnt}, m_dcnt);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.out_ram_wr   = 1'b0;
      bus.mux_sel      = 2'b00;
      bus.egress_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic push1(input logic [31:0] w);
      bus.out_ram_wr = 1'b1;
      bus.mux_sel    = 2'b01;
      bus.fifo_out1  = w;
      tick();
      bus.out_ram_wr = 1'b0;
   endtask

   initial begin
      bus.fifo_out1 = '0;
      bus.fifo_out2 = '0;
      bus.fifo_out3 = '0;
      do_reset();
      chk_en = 1'b1;

      // reset state
      check("rst_count", {28'b0, count}, 32'd0);
      check("rst_empty", {31'b0, empty}, 32'd1);
      check("rst_full",  {31'b0, full},  32'd0);
      check("rst_valid", {31'b0, bus.egress_valid}, 32'd0);
      check("rst_drop",  {31'b0, drop},  32'd0);

      // single push from source 2 appears next cycle
      bus.out_ram_wr = 1'b1;
      bus.mux_sel    = 2'b10;
      bus.fifo_out2  = 32'hA5A5_0002;
      tick();
      idle();
      check("p2_valid", {31'b0, bus.egress_valid}, 32'd1);
      check("p2_data",  bus.egress_data, 32'hA5A5_0002);
      check("p2_count", {28'b0, count}, 32'd1);
      bus.egress_ready = 1'b1;
      tick();
      idle();
      check("p2_drained", {31'b0, empty}, 32'd1);

      // fill, overflow, drain in order
      for (int i = 1; i <= 8; i++) push1(i);
      check("fill_full",  {31'b0, full}, 32'd1);
      check("fill_count", {28'b0, count}, 32'd8);
      push1(32'd99);
      check("ovf_drop",  {31'b0, drop}, 32'd1);
      check("ovf_count", {28'b0, count}, 32'd8);
      tick();
      check("ovf_drop_clr", {31'b0, drop}, 32'd0);
      bus.egress_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check("drain_order", bus.egress_data, i);
         tick();
      end
      idle();
      check("drain_empty", {31'b0, empty}, 32'd1);

      // push into full queue with simultaneous pop
      for (int i = 1; i <= 8; i++) push1(i);
      bus.out_ram_wr   = 1'b1;
      bus.mux_sel      = 2'b01;
      bus.fifo_out1    = 32'd9;
      bus.egress_ready = 1'b1;
      check("fp_head", bus.egress_data, 32'd1);
      tick();
      bus.out_ram_wr = 1'b0;
      check("fp_nodrop", {31'b0, drop}, 32'd0);
      check("fp_count",  {28'b0, count}, 32'd8);
      for (int i = 2; i <= 9; i++) begin
         check("fp_order", bus.egress_data, i);
         tick();
      end
      idle();
      check("fp_empty", {31'b0, empty}, 32'd1);

      // streaming through source 3 wraps the pointers
      bus.out_ram_wr = 1'b1;
      bus.mux_sel    = 2'b11;
      bus.fifo_out3  = 32'd100;
      tick();
      bus.egress_ready = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         bus.fifo_out3 = 100 + i;
         check("str_head", bus.egress_data, 100 + i - 1);
         tick();
         check("str_count", {28'b0, count}, 32'd1);
      end
      bus.out_ram_wr = 1'b0;
      check("str_last", bus.egress_data, 32'd120);
      tick();
      idle();
      check("str_empty", {31'b0, empty}, 32'd1);

      // write with no source selected
      do_reset();
      push1(32'h0000_BEEF);
      bus.out_ram_wr = 1'b1;
      bus.mux_sel    = 2'b00;
      tick();
      idle();
      check("nosel_drop",  {31'b0, drop}, 32'd1);
      check("nosel_count", {28'b0, count}, 32'd1);
`ifdef EGRESS_DROP_CNT_EN
      check("nosel_dcnt", {16'b0, drop_cnt}, 32'd1);
`endif
      tick();
      check("nosel_drop_clr", {31'b0, drop}, 32'd0);

      // reset mid-operation with a coincident push
      push1(32'd11);
      push1(32'd12);
      check("mid_count3", {28'b0, count}, 32'd3);
      bus.out_ram_wr = 1'b1;
      bus.mux_sel    = 2'b01;
      bus.fifo_out1  = 32'd13;
      reset_n        = 1'b0;
      tick();
      reset_n = 1'b1;
      idle();
      check("mid_count", {28'b0, count}, 32'd0);
      check("mid_empty", {31'b0, empty}, 32'd1);
      check("mid_valid", {31'b0, bus.egress_valid}, 32'd0);
      bus.egress_ready = 1'b1;
      tick();
      idle();
      check("mid_still_empty", {31'b0, empty}, 32'd1);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
